// File: rtl/gray_counter_if.sv
// gray_counter_if: stimulus and Gray-word handshake bundle for gray_counter
interface gray_counter_if #(parameter int WIDTH = 32);
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] o;
  logic o_valid;
  logic o_ready;
  logic wrap;
  modport master(output en, up, load, load_val, o_ready, input o, o_valid, wrap);
  modport slave(input en, up, load, load_val, o_ready, output o, o_valid, wrap);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down binary count presented as a registered Gray word over a valid/ready handshake
module gray_counter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  gray_counter_if.slave bus
);
  typedef enum logic {IDLE, VALID} state_t;
  state_t state, nextState;
  logic [WIDTH-1:0] count, nextCount, step, grayQ;
  logic fire, nextWrap, wrapQ;
  always_comb begin
    fire = state == VALID && bus.o_ready;
    step = bus.up ? count + 1'b1 : count - 1'b1;
    nextState = bus.load || bus.en || (state == VALID && !fire) ? VALID : IDLE;
    nextCount = bus.load ? bus.load_val : fire ? step : count;
    nextWrap = !bus.load && fire && (bus.up ? &count : ~|count);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      grayQ <= '0;
      wrapQ <= 1'b0;
    end else begin
      state <= nextState;
      count <= nextCount;
      grayQ <= nextCount ^ (nextCount >> 1);
      wrapQ <= nextWrap;
    end
  end
  assign bus.o = grayQ;
  assign bus.o_valid = state == VALID;
  assign bus.wrap = wrapQ;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: randomized scoreboard check of gray_counter against an arithmetic count model
module tb_gray_counter;
  localparam int W = 4;
  localparam int M = 1 << W;
  typedef struct {
    bit v;
    logic [W-1:0] o;
    bit w;
    bit s;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  gray_counter_if #(.WIDTH(W)) bus();
  gray_counter #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int mcnt = 0;
  bit mval = 0;
  bit curUp = 1;
  logic [W-1:0] prevO = '0;
  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv, input bit rd);
    exp_t x;
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.up = u;
    bus.load = l;
    bus.load_val = lv[W-1:0];
    bus.o_ready = rd;
    x.w = 0;
    x.s = 0;
    if (r) begin
      mcnt = 0;
      mval = 0;
    end else if (l) begin
      mcnt = lv % M;
      mval = 1;
    end else if (!mval) begin
      mval = e;
    end else if (rd) begin
      x.w = u ? (mcnt == M - 1) : (mcnt == 0);
      mcnt = (mcnt + (u ? 1 : M - 1)) % M;
      mval = e;
      x.s = 1;
    end
    x.v = mval;
    x.o = W'(mcnt ^ (mcnt >> 1));
    q.push_back(x);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("o_valid", int'(bus.o_valid), int'(x.v));
        check("o", int'(bus.o), int'(x.o));
        check("wrap", int'(bus.wrap), int'(x.w));
        if (x.s && x.v) check("one_bit_step", $countones(bus.o ^ prevO), 1);
      end
      prevO = bus.o;
    end
  end
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.up = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.o_ready = 1'b0;
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 15, 0);
    repeat (2) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 5, 0);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 9, 1);
    repeat (3) cyc(0, 0, 1, 0, 0, 1);
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) curUp = ~curUp;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, curUp,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 2) == 0 ? M - 1 : int'($urandom_range(0, M - 1)),
          $urandom_range(0, 3) != 0);
    end
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
